bp_update_unit: RTL and testbench
=================================

Name: bp_update_unit

Overview:
- Execute-side counterpart of the fetch branch predictor.
- Accepts resolved control-flow instructions from the branch ALU and compares the actual outcome with the prediction carried down the pipe.
- On a misprediction it issues a one-cycle fetch redirect.
- Every accepted instruction is queued in a small FIFO, which drains one entry per cycle onto the predictor update port.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, >=2).
- CNT_W, 32, width of the mispredict and resolve counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- res_valid_i  in  1  resolved instruction valid.
- res_ready_o  out  1  unit can accept a resolved instruction.
- res_pc_i  in  64  PC of the resolved instruction.
- res_type_i  in  btb_type_t  BRANCH/CALL/RETURN/JUMP.
- res_pred_taken_i  in  1  predicted direction carried from fetch.
- res_pred_target_i  in  64  predicted target carried from fetch.
- res_taken_i  in  1  actual direction.
- res_target_i  in  64  actual target.
- res_bhr_i  in  10  BHR snapshot used at prediction time.
- flush_i  in  1  older-instruction flush; current input is squashed.
- redirect_o  out  1  fetch redirect pulse.
- redirect_pc_o  out  64  fetch restart address.
- update_en_o  out  1  predictor update valid.
- pc_u_o  out  64  update PC.
- target_u_o  out  64  update target.
- taken_u_o  out  1  update direction.
- type_u_o  out  btb_type_t  update type.
- ret_addr_u_o  out  64  return address for RAS push.
- bhr_u_o  out  10  update BHR snapshot.
- mispredict_cnt_o  out  CNT_W  mispredictions since reset.
- resolve_cnt_o  out  CNT_W  accepted resolves since reset.

Behaviour:
- Accept condition: accept = res_valid_i & res_ready_o & ~flush_i.
- Ready: res_ready_o = ~full, combinational from FIFO state. No dependence on res_valid_i.
- Mispredict condition: mispredict = accept & ((res_pred_taken_i != res_taken_i) | (res_taken_i & (res_pred_target_i != res_target_i))).
- Redirect: registered. One cycle after a mispredicting accept, redirect_o=1 for exactly one cycle.
  - redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4.
  - Otherwise redirect_o=0; redirect_pc_o holds its last value.
- Correctly predicted instructions produce no redirect.
- flush_i=1 with res_valid_i=1:
  - The instruction is not accepted, gets no FIFO entry, no redirect and no counter increment.
  - A redirect already registered from the previous cycle still fires.
- FIFO entry contents: {pc, target=res_target_i, taken, type, ret_addr=res_pc_i+4, bhr}.
  - res_pc_i+4 is 64-bit, wraps modulo 2^64.
- FIFO storage: circular buffer with read/write pointers of log2(DEPTH)+1 bits.
  - empty: pointers are equal.
  - full: indices are equal and the MSBs differ.
- Drain: whenever the FIFO is non-empty, the head is presented combinationally on the update outputs with update_en_o=1, and the head is popped that cycle (the predictor always consumes).
  - update_en_o=0 when empty.
  - The data outputs are don't-care when update_en_o=0.
- Latency: an entry accepted in cycle N into an empty FIFO appears on update_en_o in cycle N+1.
- Simultaneous push and pop: allowed in the same cycle.
  - The count is unchanged.
  - When full, no push occurs because ready=0. The pop frees the slot for the next cycle.
- Counters:
  - resolve_cnt_o increments on every accept.
  - mispredict_cnt_o increments on every mispredict.
  - Both wrap modulo 2^CNT_W.
- Reset (synchronous, takes priority over all inputs):
  - Pointers cleared, so the FIFO is empty.
  - redirect_o=0, redirect_pc_o=0, update_en_o=0, both counters 0.
  - res_ready_o=1 in the first cycle after reset.
  - Reset mid-drain discards all queued entries.
  - An input presented in the reset cycle is dropped.
- Order: updates leave the FIFO in acceptance order. Entries are never reordered or merged.

Test Plan:
- Correct prediction: BRANCH, pc=0x1000, pred_taken=1, taken=1, both targets=0x1040 -> no redirect; next cycle update_en_o=1, pc_u_o=0x1000, taken_u_o=1, target_u_o=0x1040, ret_addr_u_o=0x1004; resolve_cnt_o=1, mispredict_cnt_o=0.
- Direction mispredict: BRANCH, pc=0x2000, pred_taken=1, taken=0 -> next cycle redirect_o=1 with redirect_pc_o=0x2004 for one cycle only; mispredict_cnt_o=1.
- Target mispredict: RETURN, pc=0x3000, pred_target=0x4000, target=0x5000, taken=1 -> redirect to 0x5000; type_u_o=RETURN, bhr_u_o equals res_bhr_i (e.g. 0x2A5).
- Full FIFO: DEPTH=4, fill through the back-to-back accept path, then check ready.
  - Mechanism: the predictor pops every cycle, so the FIFO can only reach 4 entries if the bench forces the drain to stall. The bench sees no stall hook in this spec, so this scenario must be run by holding the pop off via a bench-only force on the pop signal.
  - With pop forced off: 4 valid inputs -> res_ready_o=0 after the 4th; a 5th input is held, not accepted; resolve_cnt_o=4.
  - Release the force -> 4 updates drain on consecutive cycles in order.
- Flush: res_valid_i=1 with flush_i=1 on a mispredicting branch -> no redirect, no FIFO entry, counters unchanged.
- Reset mid-operation: 3 entries queued plus a pending redirect, then reset=1 for one cycle -> next cycle update_en_o=0, redirect_o=0, counters 0, res_ready_o=1.

Source files
------------

// File: rtl/bp_update_unit.sv
// Branch predictor update unit: checks resolved control flow against the fetch-time
// prediction, redirects fetch on a mispredict, and queues predictor training updates.
package bp_update_pkg;
  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    CALL   = 2'd1,
    RETURN = 2'd2,
    JUMP   = 2'd3
  } btb_type_t;
endpackage

module bp_update_unit
  import bp_update_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [63:0]       res_pc_i,
  input  btb_type_t         res_type_i,
  input  logic              res_pred_taken_i,
  input  logic [63:0]       res_pred_target_i,
  input  logic              res_taken_i,
  input  logic [63:0]       res_target_i,
  input  logic [9:0]        res_bhr_i,
  input  logic              flush_i,
  output logic              redirect_o,
  output logic [63:0]       redirect_pc_o,
  output logic              update_en_o,
  output logic [63:0]       pc_u_o,
  output logic [63:0]       target_u_o,
  output logic              taken_u_o,
  output btb_type_t         type_u_o,
  output logic [63:0]       ret_addr_u_o,
  output logic [9:0]        bhr_u_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o,
  output logic [CNT_W-1:0]  resolve_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
    logic        taken;
    btb_type_t   btype;
    logic [63:0] ret_addr;
    logic [9:0]  bhr;
  } entry_t;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, accept, mispredict, pop;
  logic [63:0] fall_through;
  entry_t      head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign res_ready_o  = ~full;
  assign accept       = res_valid_i & res_ready_o & ~flush_i;
  assign mispredict   = accept & ((res_pred_taken_i != res_taken_i) |
                                  (res_taken_i & (res_pred_target_i != res_target_i)));
  assign fall_through = res_pc_i + 64'd4;

  // The predictor always consumes, so the head is popped whenever one exists.
  assign pop          = ~empty;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign update_en_o  = pop;
  assign pc_u_o       = head.pc;
  assign target_u_o   = head.target;
  assign taken_u_o    = head.taken;
  assign type_u_o     = head.btype;
  assign ret_addr_u_o = head.ret_addr;
  assign bhr_u_o      = head.bhr;

  // NOTE: payload storage has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= '{pc:       res_pc_i,
                               target:   res_target_i,
                               taken:    res_taken_i,
                               btype:    res_type_i,
                               ret_addr: fall_through,
                               bhr:      res_bhr_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      redirect_o       <= 1'b0;
      redirect_pc_o    <= '0;
      mispredict_cnt_o <= '0;
      resolve_cnt_o    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      redirect_o <= mispredict;
      if (mispredict) begin
        redirect_pc_o    <= res_taken_i ? res_target_i : fall_through;
        mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
      end
      if (accept) resolve_cnt_o <= resolve_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed bench for bp_update_unit: prediction checks, redirects, flush, FIFO fill/drain, reset.
module tb_bp_update_unit;
  import bp_update_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [63:0] res_pc_i;
  btb_type_t   res_type_i;
  logic        res_pred_taken_i;
  logic [63:0] res_pred_target_i;
  logic        res_taken_i;
  logic [63:0] res_target_i;
  logic [9:0]  res_bhr_i;
  logic        flush_i;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic        update_en_o;
  logic [63:0] pc_u_o;
  logic [63:0] target_u_o;
  logic        taken_u_o;
  btb_type_t   type_u_o;
  logic [63:0] ret_addr_u_o;
  logic [9:0]  bhr_u_o;
  logic [31:0] mispredict_cnt_o;
  logic [31:0] resolve_cnt_o;

  int checks = 0;
  int errors = 0;

  bp_update_unit #(.DEPTH(4), .CNT_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .res_valid_i       (res_valid_i),
    .res_ready_o       (res_ready_o),
    .res_pc_i          (res_pc_i),
    .res_type_i        (res_type_i),
    .res_pred_taken_i  (res_pred_taken_i),
    .res_pred_target_i (res_pred_target_i),
    .res_taken_i       (res_taken_i),
    .res_target_i      (res_target_i),
    .res_bhr_i         (res_bhr_i),
    .flush_i           (flush_i),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o),
    .update_en_o       (update_en_o),
    .pc_u_o            (pc_u_o),
    .target_u_o        (target_u_o),
    .taken_u_o         (taken_u_o),
    .type_u_o          (type_u_o),
    .ret_addr_u_o      (ret_addr_u_o),
    .bhr_u_o           (bhr_u_o),
    .mispredict_cnt_o  (mispredict_cnt_o),
    .resolve_cnt_o     (resolve_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input btb_type_t t,
                       input logic pt, input logic [63:0] ptgt, input logic tk,
                       input logic [63:0] tgt, input logic [9:0] bhr);
    res_valid_i       = v;
    res_pc_i          = pc;
    res_type_i        = t;
    res_pred_taken_i  = pt;
    res_pred_target_i = ptgt;
    res_taken_i       = tk;
    res_target_i      = tgt;
    res_bhr_i         = bhr;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, BRANCH, 1'b0, 64'h0, 1'b0, 64'h0, 10'h0);
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_redirect", 64'(redirect_o), 64'd0);
    check("rst_redirect_pc", redirect_pc_o, 64'd0);
    check("rst_update_en", 64'(update_en_o), 64'd0);
    check("rst_mis_cnt", 64'(mispredict_cnt_o), 64'd0);
    check("rst_res_cnt", 64'(resolve_cnt_o), 64'd0);
    check("rst_ready", 64'(res_ready_o), 64'd1);

    // Correct prediction
    drive(1'b1, 64'h1000, BRANCH, 1'b1, 64'h1040, 1'b1, 64'h1040, 10'h155);
    tick();
    idle();
    check("ok_redirect", 64'(redirect_o), 64'd0);
    check("ok_update_en", 64'(update_en_o), 64'd1);
    check("ok_pc_u", pc_u_o, 64'h1000);
    check("ok_taken_u", 64'(taken_u_o), 64'd1);
    check("ok_target_u", target_u_o, 64'h1040);
    check("ok_ret_addr_u", ret_addr_u_o, 64'h1004);
    check("ok_type_u", 64'(type_u_o), 64'(BRANCH));
    check("ok_bhr_u", 64'(bhr_u_o), 64'h155);
    check("ok_res_cnt", 64'(resolve_cnt_o), 64'd1);
    check("ok_mis_cnt", 64'(mispredict_cnt_o), 64'd0);
    tick();
    check("ok_drained", 64'(update_en_o), 64'd0);

    // Direction mispredict: predicted taken, actually not taken
    drive(1'b1, 64'h2000, BRANCH, 1'b1, 64'h2080, 1'b0, 64'h2080, 10'h001);
    tick();
    idle();
    check("dir_redirect", 64'(redirect_o), 64'd1);
    check("dir_redirect_pc", redirect_pc_o, 64'h2004);
    check("dir_mis_cnt", 64'(mispredict_cnt_o), 64'd1);
    check("dir_res_cnt", 64'(resolve_cnt_o), 64'd2);
    check("dir_taken_u", 64'(taken_u_o), 64'd0);
    tick();
    check("dir_redirect_pulse", 64'(redirect_o), 64'd0);
    check("dir_redirect_pc_hold", redirect_pc_o, 64'h2004);

    // Target mispredict on a RETURN
    drive(1'b1, 64'h3000, RETURN, 1'b1, 64'h4000, 1'b1, 64'h5000, 10'h2A5);
    tick();
    idle();
    check("tgt_redirect", 64'(redirect_o), 64'd1);
    check("tgt_redirect_pc", redirect_pc_o, 64'h5000);
    check("tgt_type_u", 64'(type_u_o), 64'(RETURN));
    check("tgt_bhr_u", 64'(bhr_u_o), 64'h2A5);
    check("tgt_target_u", target_u_o, 64'h5000);
    check("tgt_ret_addr_u", ret_addr_u_o, 64'h3004);
    check("tgt_mis_cnt", 64'(mispredict_cnt_o), 64'd2);
    tick();
    check("tgt_redirect_pulse", 64'(redirect_o), 64'd0);

    // Flushed mispredicting branch is dropped entirely
    flush_i = 1'b1;
    drive(1'b1, 64'h6000, BRANCH, 1'b1, 64'h6040, 1'b0, 64'h6040, 10'h0);
    tick();
    flush_i = 1'b0;
    idle();
    check("fl_redirect", 64'(redirect_o), 64'd0);
    check("fl_update_en", 64'(update_en_o), 64'd0);
    check("fl_res_cnt", 64'(resolve_cnt_o), 64'd3);
    check("fl_mis_cnt", 64'(mispredict_cnt_o), 64'd2);

    // Registered redirect still fires while the following input is flushed
    drive(1'b1, 64'h6100, JUMP, 1'b0, 64'h0, 1'b1, 64'h6200, 10'h0);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 64'h6300, BRANCH, 1'b1, 64'h6400, 1'b0, 64'h6400, 10'h0);
    check("flp_redirect", 64'(redirect_o), 64'd1);
    check("flp_redirect_pc", redirect_pc_o, 64'h6200);
    check("flp_pc_u", pc_u_o, 64'h6100);
    tick();
    flush_i = 1'b0;
    idle();
    check("flp_redirect_after", 64'(redirect_o), 64'd0);
    check("flp_redirect_pc_hold", redirect_pc_o, 64'h6200);
    check("flp_update_en", 64'(update_en_o), 64'd0);
    check("flp_res_cnt", 64'(resolve_cnt_o), 64'd4);
    check("flp_mis_cnt", 64'(mispredict_cnt_o), 64'd3);

    // Full FIFO: stall the drain, fill four entries back to back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force dut.pop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h7000 + 64'(16 * i), BRANCH, 1'b0, 64'h0, 1'b0, 64'h0, 10'(i));
      check($sformatf("full_ready_%0d", i), 64'(res_ready_o), 64'd1);
      tick();
    end
    check("full_ready_low", 64'(res_ready_o), 64'd0);
    check("full_res_cnt", 64'(resolve_cnt_o), 64'd4);
    drive(1'b1, 64'h7040, BRANCH, 1'b0, 64'h0, 1'b0, 64'h0, 10'h3FF);
    tick();
    idle();
    check("full_held_ready", 64'(res_ready_o), 64'd0);
    check("full_held_res_cnt", 64'(resolve_cnt_o), 64'd4);
    release dut.pop;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_en_%0d", i), 64'(update_en_o), 64'd1);
      check($sformatf("drain_pc_%0d", i), pc_u_o, 64'h7000 + 64'(16 * i));
      check($sformatf("drain_bhr_%0d", i), 64'(bhr_u_o), 64'(i));
      tick();
      check($sformatf("drain_ready_%0d", i), 64'(res_ready_o), 64'd1);
    end
    check("drain_empty", 64'(update_en_o), 64'd0);

    // Reset mid-operation: three queued entries plus a pending redirect
    force dut.pop = 1'b0;
    drive(1'b1, 64'h8000, BRANCH, 1'b0, 64'h0, 1'b0, 64'h0, 10'h0);
    tick();
    drive(1'b1, 64'h8010, BRANCH, 1'b0, 64'h0, 1'b0, 64'h0, 10'h0);
    tick();
    drive(1'b1, 64'h8020, CALL, 1'b0, 64'h0, 1'b1, 64'h9000, 10'h0);
    tick();
    check("mid_redirect", 64'(redirect_o), 64'd1);
    check("mid_redirect_pc", redirect_pc_o, 64'h9000);
    check("mid_res_cnt", 64'(resolve_cnt_o), 64'd7);
    check("mid_mis_cnt", 64'(mispredict_cnt_o), 64'd1);
    release dut.pop;
    reset = 1'b1;
    drive(1'b1, 64'h8030, BRANCH, 1'b1, 64'h0, 1'b0, 64'h0, 10'h0);
    tick();
    reset = 1'b0;
    idle();
    check("mid_rst_update_en", 64'(update_en_o), 64'd0);
    check("mid_rst_redirect", 64'(redirect_o), 64'd0);
    check("mid_rst_redirect_pc", redirect_pc_o, 64'd0);
    check("mid_rst_res_cnt", 64'(resolve_cnt_o), 64'd0);
    check("mid_rst_mis_cnt", 64'(mispredict_cnt_o), 64'd0);
    check("mid_rst_ready", 64'(res_ready_o), 64'd1);
    tick();
    check("mid_rst_dropped", 64'(update_en_o), 64'd0);
    check("mid_rst_no_redirect", 64'(redirect_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
